// File: rtl/oq_count_rmw_engine.sv
// ---------------------------------------------------------------------------
// oq_count_rmw_engine
//
// Read-modify-write sequencer for the output-queue counter RAM. Add, subtract
// and clear events are applied to per-queue counters through one synchronous
// read-before-write RAM port. After reset every entry is zeroed, then updates
// are serialised so that none is ever lost.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   add_req/add_q/add_val     add request (held until add_ack)
//   sub_req/sub_q/sub_val     subtract request (held until sub_ack)
//   clr_req/clr_q             clear request (held until clr_ack)
//   add_ack/sub_ack/clr_ack   single-cycle accepts, combinational, IDLE only
//   ram_addr/ram_we/ram_din   RAM port (same clock)
//   ram_dout                  RAM read data, one cycle after the address
//   overflow_err              one-cycle pulse: add saturated at max
//   underflow_err             one-cycle pulse: subtract clamped at zero
//   busy                      high during INIT and UPDATE
// ---------------------------------------------------------------------------
module oq_count_rmw_engine #(
  parameter int REG_WIDTH         = 32,
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int ADDR_WIDTH        = $clog2(NUM_OUTPUT_QUEUES),
  parameter int DELTA_WIDTH       = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   add_req,
  input  logic [ADDR_WIDTH-1:0]  add_q,
  input  logic [DELTA_WIDTH-1:0] add_val,
  output logic                   add_ack,
  input  logic                   sub_req,
  input  logic [ADDR_WIDTH-1:0]  sub_q,
  input  logic [DELTA_WIDTH-1:0] sub_val,
  output logic                   sub_ack,
  input  logic                   clr_req,
  input  logic [ADDR_WIDTH-1:0]  clr_q,
  output logic                   clr_ack,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic                   ram_we,
  output logic [REG_WIDTH-1:0]   ram_din,
  input  logic [REG_WIDTH-1:0]   ram_dout,
  output logic                   overflow_err,
  output logic                   underflow_err,
  output logic                   busy
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPDATE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_Q = ADDR_WIDTH'(NUM_OUTPUT_QUEUES - 1);

  // Result layout: {overflow, underflow, value}.
  function automatic logic [REG_WIDTH+1:0] sat_update(
    input logic [REG_WIDTH-1:0]   old_val,
    input logic [DELTA_WIDTH-1:0] add_amt,
    input logic [DELTA_WIDTH-1:0] sub_amt
  );
    logic signed [REG_WIDTH+1:0] r;
    logic signed [REG_WIDTH+1:0] max_val;
    max_val = $signed({2'b00, {REG_WIDTH{1'b1}}});
    r = $signed({2'b00, old_val})
      + $signed({{(REG_WIDTH+2-DELTA_WIDTH){1'b0}}, add_amt})
      - $signed({{(REG_WIDTH+2-DELTA_WIDTH){1'b0}}, sub_amt});
    if (r < 0)
      return {2'b01, {REG_WIDTH{1'b0}}};
    else if (r > max_val)
      return {2'b10, {REG_WIDTH{1'b1}}};
    else
      return {2'b00, r[REG_WIDTH-1:0]};
  endfunction

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic                    rr_sub;      // 1: subtract wins the next add/sub conflict

  logic [ADDR_WIDTH-1:0]   upd_q_p1;
  logic [DELTA_WIDTH-1:0]  add_amt_p1;
  logic [DELTA_WIDTH-1:0]  sub_amt_p1;
  logic [REG_WIDTH+1:0]    upd_res_p1;

  logic idle;
  logic same_q;
  logic pick_add;
  logic pick_sub;

  // ---- p0: request arbitration in IDLE (read issued) ----
  assign idle   = (state == S_IDLE);
  assign same_q = (add_q == sub_q);

  // Clear has absolute priority; a same-queue add/sub pair merges into one op.
  assign pick_add = idle & ~clr_req & add_req & (~sub_req | same_q | ~rr_sub);
  assign pick_sub = idle & ~clr_req & sub_req & (~add_req | same_q |  rr_sub);

  assign clr_ack = idle & clr_req;
  assign add_ack = pick_add;
  assign sub_ack = pick_sub;
  assign busy    = ~idle;

  always_ff @(posedge clk) begin
    if (pick_add | pick_sub) begin
      upd_q_p1   <= pick_add ? add_q : sub_q;
      add_amt_p1 <= pick_add ? add_val : '0;
      sub_amt_p1 <= pick_sub ? sub_val : '0;
    end
  end

  // ---- p1: UPDATE, old value on ram_dout, saturating write-back ----
  assign upd_res_p1 = sat_update(ram_dout, add_amt_p1, sub_amt_p1);

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    case (state)
      S_INIT: begin
        // Gated by reset_n so the RAM sees no write while reset is held.
        ram_we   = reset_n;
        ram_addr = init_cnt;
      end
      S_IDLE: begin
        if (clr_req) begin
          ram_we   = 1'b1;
          ram_addr = clr_q;
        end else if (pick_add) begin
          ram_addr = add_q;
        end else if (pick_sub) begin
          ram_addr = sub_q;
        end
      end
      S_UPDATE: begin
        ram_we   = 1'b1;
        ram_addr = upd_q_p1;
        ram_din  = upd_res_p1[REG_WIDTH-1:0];
      end
      default: begin
        ram_we = 1'b0;
      end
    endcase
  end

  // ---- control: state, init counter, round-robin, error pulses (p2) ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_INIT;
      init_cnt      <= '0;
      rr_sub        <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      overflow_err  <= (state == S_UPDATE) & upd_res_p1[REG_WIDTH+1];
      underflow_err <= (state == S_UPDATE) & upd_res_p1[REG_WIDTH];
      if (pick_add | pick_sub)
        rr_sub <= ~rr_sub;
      case (state)
        S_INIT: begin
          if (init_cnt == LAST_Q) begin
            init_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (pick_add | pick_sub)
            state <= S_UPDATE;
        end
        S_UPDATE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule
